// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU/NIC request, response and dmem port bundle
// The slave side is the arbiter; the master side is the pipeline, NIC and dmem macro.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  nic_req;
  logic                  nic_we;
  logic [ADDR_WIDTH-1:0] nic_addr;
  logic [DATA_WIDTH-1:0] nic_wdata;
  logic                  nic_lock;
  logic                  nic_gnt;
  logic                  nic_rvalid;
  logic [DATA_WIDTH-1:0] nic_rdata;

  logic                  mem_enable;
  logic                  store_enable;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [DATA_WIDTH-1:0] dmem_dataIn;
  logic [DATA_WIDTH-1:0] dmem_dataOut;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  nic_req, nic_we, nic_addr, nic_wdata, nic_lock,
    input  dmem_dataOut,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output nic_gnt, nic_rvalid, nic_rdata,
    output mem_enable, store_enable, dmem_address, dmem_dataIn
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output nic_req, nic_we, nic_addr, nic_wdata, nic_lock,
    output dmem_dataOut,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  nic_gnt, nic_rvalid, nic_rdata,
    input  mem_enable, store_enable, dmem_address, dmem_dataIn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin dmem port arbiter between CPU and NIC
// Grants are combinational; load data returns one cycle later to the issuing requester.
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_BURST   = 4,
  parameter int BURST_CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  localparam logic [0:0] OWNER_CPU = 1'b0;
  localparam logic [0:0] OWNER_NIC = 1'b1;
  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

  logic [0:0]             last_winner;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   rd_pending;
  logic [0:0]             rd_owner;

  logic burst_hold;
  logic grant_cpu;
  logic grant_nic;

  always_comb begin
    burst_hold = (last_winner == OWNER_NIC) && bus.nic_req && bus.nic_lock &&
                 (burst_cnt < BURST_MAX);
    grant_cpu  = 1'b0;
    grant_nic  = 1'b0;
    if (rst) begin
      if (burst_hold) begin
        grant_nic = 1'b1;
      end else if (bus.cpu_req && bus.nic_req) begin
        // Tie goes to whoever did not win last.
        if (last_winner == OWNER_NIC) grant_cpu = 1'b1;
        else                          grant_nic = 1'b1;
      end else if (bus.cpu_req) begin
        grant_cpu = 1'b1;
      end else if (bus.nic_req) begin
        grant_nic = 1'b1;
      end
    end
  end

  assign bus.cpu_gnt      = grant_cpu;
  assign bus.nic_gnt      = grant_nic;
  assign bus.cpu_stall    = bus.cpu_req & ~grant_cpu;
  assign bus.mem_enable   = grant_cpu | grant_nic;
  assign bus.store_enable = (grant_cpu & bus.cpu_we) | (grant_nic & bus.nic_we);
  assign bus.dmem_address = grant_cpu ? bus.cpu_addr  :
                            grant_nic ? bus.nic_addr  : {ADDR_WIDTH{1'b0}};
  assign bus.dmem_dataIn  = grant_cpu ? bus.cpu_wdata :
                            grant_nic ? bus.nic_wdata : {DATA_WIDTH{1'b0}};

  // A reset in the return cycle suppresses the pending read.
  assign bus.cpu_rvalid = rst & rd_pending & (rd_owner == OWNER_CPU);
  assign bus.nic_rvalid = rst & rd_pending & (rd_owner == OWNER_NIC);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.dmem_dataOut : {DATA_WIDTH{1'b0}};
  assign bus.nic_rdata  = bus.nic_rvalid ? bus.dmem_dataOut : {DATA_WIDTH{1'b0}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_winner <= OWNER_NIC;
      burst_cnt   <= '0;
      rd_pending  <= 1'b0;
      rd_owner    <= OWNER_CPU;
    end else begin
      rd_pending <= (grant_cpu & ~bus.cpu_we) | (grant_nic & ~bus.nic_we);
      if (grant_cpu) begin
        last_winner <= OWNER_CPU;
        rd_owner    <= OWNER_CPU;
      end else if (grant_nic) begin
        last_winner <= OWNER_NIC;
        rd_owner    <= OWNER_NIC;
      end
      if (grant_nic && bus.nic_lock) begin
        if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
      end
    end
  end
endmodule
